bus_collector: RTL and testbench
================================

// Module: bus_collector
// PURPOSE
//  Reassembles lane results into one ordered stream; counterpart of the round-robin bus distributor.
//  Words arrive on NUM_INPUTS lanes, each with its own one-cycle valid pulse, in any relative order.
//  Each lane is buffered in a private FIFO; words are emitted in strict lane order 0,1,..,N-1,0,..
//  Output is a single valid/ready stream, so per-lane results leave in original distribution order.
// PARAMETERS
//  NUM_INPUTS  4  lane count; >=2
//  DATA_WIDTH  6  bits per word
//  DEPTH       2  per-lane FIFO entries; power of 2, >=2
// PORTS
//  clk_in          in   1                      single clock; all logic on posedge
//  rst_in          in   1                      synchronous, active-high reset
//  data_valid_in   in   NUM_INPUTS             per-lane write strobe
//  data_in         in   NUM_INPUTS x DATA_WIDTH packed per-lane data
//  lane_ready_out  out  NUM_INPUTS             1 = lane FIFO not full (registered)
//  data_out        out  DATA_WIDTH             output word
//  valid_out       out  1                      data_out valid
//  ready_in        in   1                      downstream accepts when valid_out&&ready_in
//  ix_out          out  $clog2(NUM_INPUTS)     lane index expected next
//  overflow_out    out  1                      sticky: a write was dropped
// BEHAVIOUR
//  Reset: all FIFOs emptied, ix_out=0, valid_out=0, data_out=0, overflow_out=0, lane_ready_out=all 1.
//  Reset mid-operation discards buffered and in-flight words; no partial output after rst_in falls.
//  Lane write: data_valid_in[i] && lane_ready_out[i] pushes data_in[i] into FIFO i.
//  Full lane: write with lane_ready_out[i]=0 is dropped, overflow_out<=1 until reset.
//   Rule holds even if FIFO i pops the same cycle (ready is registered, no same-cycle credit).
//  Simultaneous push and pop on one lane: both occur, occupancy unchanged.
//  Output register (one stage): loads when (!valid_out || ready_in) && FIFO[ix_out] non-empty;
//   on load: pop FIFO[ix_out], valid_out<=1, ix_out<=ix_out+1, wrapping NUM_INPUTS-1 -> 0.
//   If the load condition holds but FIFO[ix_out] is empty: valid_out<=0 when ready_in, ix_out holds.
//  valid_out&&!ready_in: data_out, valid_out and ix_out hold; lane FIFOs keep filling to DEPTH.
//  Strict order: never skips an empty lane; other lanes buffer until the expected lane arrives.
//  Latency: word pushed into empty FIFO[ix_out] at edge N -> valid_out=1 after edge N+1.
//  Throughput: 1 word/cycle when lanes keep up and ready_in=1.
//  Per-lane FIFO pointers are $clog2(DEPTH) bits wide plus 1 wrap bit; full/empty come from that bit.
// CONFIGURATION
//  BUS_COLLECTOR_STATS_EN defined: adds outputs word_count_out[31:0] and drop_count_out[15:0].
//   word_count_out increments on each valid_out&&ready_in.
//   drop_count_out increments on each dropped lane write, several lanes in one cycle counted
//   (+popcount), and saturates at 16'hFFFF.
//   Both counters reset to 0; word_count_out wraps at 2^32.
//  Undefined: neither port exists; core behaviour is identical.
// TESTING
//  1 Reset: assert rst_in 2 cycles -> valid_out=0, ix_out=0, overflow_out=0, lane_ready_out=4'b1111.
//  2 In-order: lanes 0..3 pulse 6'h01..6'h04 on cycles 0..3, ready_in=1 ->
//    data_out 01,02,03,04 on cycles 2..5; ix_out ends at 0.
//  3 Out-of-order: lane2=6'h22 @c0, lane1=6'h11 @c1, lane0=6'h00 @c2 ->
//    valid_out=0 through c3, then 00,11,22 on consecutive cycles.
//  4 Overflow: DEPTH=2, lane1 written 3 times while lane0 empty ->
//    lane_ready_out[1]=0 after 2nd write, 3rd word dropped, overflow_out=1, stays 1.
//  5 Backpressure/wrap: 8 round-robin words, ready_in toggling 1,0 ->
//    output order 0..7 intact, data held while !ready_in, ix_out wraps 3->0 twice.
//  6 STATS_EN: repeat test 4 then drain -> word_count_out=2, drop_count_out=1;
//    reset mid-run -> both counters 0.

Source files
------------

// File: rtl/bus_collector.sv
// bus_collector: buffers each lane in its own FIFO and drains the lanes in strict round-robin order into one valid/ready stream.
// Optional feature macro BUS_COLLECTOR_STATS_EN adds the word_count_out / drop_count_out statistics ports.
module bus_collector #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 2
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic [NUM_INPUTS-1:0]                 data_valid_in,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_in,
  output logic [NUM_INPUTS-1:0]                 lane_ready_out,
  output logic [DATA_WIDTH-1:0]                 data_out,
  output logic                                  valid_out,
  input  logic                                  ready_in,
  output logic [$clog2(NUM_INPUTS)-1:0]         ix_out,
  output logic                                  overflow_out
`ifdef BUS_COLLECTOR_STATS_EN
  ,
  output logic [31:0]                           word_count_out,
  output logic [15:0]                           drop_count_out
`endif
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]       mem [NUM_INPUTS][DEPTH];
  logic [NUM_INPUTS-1:0][AW:0] wr_ptr;
  logic [NUM_INPUTS-1:0][AW:0] rd_ptr;
  logic [NUM_INPUTS-1:0][AW:0] wr_ptr_nxt;
  logic [NUM_INPUTS-1:0][AW:0] rd_ptr_nxt;
  logic [NUM_INPUTS-1:0]       push;
  logic [NUM_INPUTS-1:0]       pop;
  logic [NUM_INPUTS-1:0]       drop;
  logic [NUM_INPUTS-1:0]       lane_empty;
  logic [NUM_INPUTS-1:0]       lane_full_nxt;
  logic                        out_free;
  logic                        load;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      lane_empty[i] = (wr_ptr[i] == rd_ptr[i]);
    end
  end

  // Acceptance uses only the registered ready, so a lane that pops this cycle
  // still refuses a write it flagged as full on the previous edge.
  always_comb begin
    out_free = !valid_out || ready_in;
    load     = out_free && !lane_empty[ix_out];
    push     = data_valid_in & lane_ready_out;
    drop     = data_valid_in & ~lane_ready_out;
    pop      = '0;
    if (load) pop[ix_out] = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      wr_ptr_nxt[i]    = wr_ptr[i] + {{AW{1'b0}}, push[i]};
      rd_ptr_nxt[i]    = rd_ptr[i] + {{AW{1'b0}}, pop[i]};
      lane_full_nxt[i] = (wr_ptr_nxt[i][AW] != rd_ptr_nxt[i][AW]) &&
                         (wr_ptr_nxt[i][AW-1:0] == rd_ptr_nxt[i][AW-1:0]);
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= data_in[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      lane_ready_out <= '1;
      data_out       <= '0;
      valid_out      <= 1'b0;
      ix_out         <= '0;
      overflow_out   <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      lane_ready_out <= ~lane_full_nxt;
      if (|drop) overflow_out <= 1'b1;
      if (load) begin
        data_out  <= mem[ix_out][rd_ptr[ix_out][AW-1:0]];
        valid_out <= 1'b1;
        ix_out    <= (ix_out == IW'(NUM_INPUTS - 1)) ? '0 : ix_out + IW'(1);
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef BUS_COLLECTOR_STATS_EN
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_count_out} + 17'($countones(drop));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_count_out <= '0;
      drop_count_out <= '0;
    end else begin
      if (valid_out && ready_in) word_count_out <= word_count_out + 32'd1;
      drop_count_out <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_bus_collector.sv
// Self-checking bench for bus_collector: table-driven cycle vectors plus a per-lane scoreboard
// that predicts the strict lane-order output stream.
module tb_bus_collector;

  localparam int N = 4;
  localparam int W = 6;

  typedef struct {
    logic             rst;
    logic [N-1:0]     vld;
    logic [N-1:0][W-1:0] dat;
    logic             rdy;
    logic             ev;
    logic [W-1:0]     ed;
    logic [1:0]       eix;
  } vec_t;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [N-1:0]        data_valid_in;
  logic [N-1:0][W-1:0] data_in;
  logic [N-1:0]        lane_ready_out;
  logic [W-1:0]        data_out;
  logic                valid_out;
  logic                ready_in;
  logic [1:0]          ix_out;
  logic                overflow_out;
`ifdef BUS_COLLECTOR_STATS_EN
  logic [31:0]         word_count_out;
  logic [15:0]         drop_count_out;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] lane_q [N][$];
  int sb_ix = 0;
  vec_t tbl [15];

  bus_collector #(.NUM_INPUTS(N), .DATA_WIDTH(W), .DEPTH(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_valid_in  (data_valid_in),
    .data_in        (data_in),
    .lane_ready_out (lane_ready_out),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .ix_out         (ix_out),
    .overflow_out   (overflow_out)
`ifdef BUS_COLLECTOR_STATS_EN
    ,
    .word_count_out (word_count_out),
    .drop_count_out (drop_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // The word on data_out must be the oldest word of the lane the model expects next.
  task automatic monitorSample();
    if (!rst_in && valid_out) begin
      if (lane_q[sb_ix].size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL sb_extra: got word 0x%0h from lane %0d, want no word", data_out, sb_ix);
      end else begin
        checkOutput("sb_data", 32'(data_out), 32'(lane_q[sb_ix][0]));
        checkOutput("sb_ix", 32'(ix_out), 32'((sb_ix + 1) % N));
        if (ready_in) begin
          void'(lane_q[sb_ix].pop_front());
          sb_ix = (sb_ix + 1) % N;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    monitorSample();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] vld, input logic [N-1:0][W-1:0] dat,
                               input logic rdy, input logic [N-1:0] keep);
    data_valid_in = vld;
    data_in       = dat;
    ready_in      = rdy;
    for (int i = 0; i < N; i++) begin
      if (vld[i] && keep[i]) lane_q[i].push_back(dat[i]);
    end
  endtask

  task automatic resetDut();
    rst_in        = 1'b1;
    data_valid_in = '0;
    data_in       = '0;
    ready_in      = 1'b1;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    sb_ix = 0;
    repeat (2) tick();
    rst_in = 1'b0;
    checkOutput("rst_valid", 32'(valid_out), 32'd0);
    checkOutput("rst_ix", 32'(ix_out), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_out), 32'd0);
    checkOutput("rst_lane_ready", 32'(lane_ready_out), 32'hF);
    checkOutput("rst_data", 32'(data_out), 32'd0);
`ifdef BUS_COLLECTOR_STATS_EN
    checkOutput("rst_word_count", word_count_out, 32'd0);
    checkOutput("rst_drop_count", 32'(drop_count_out), 32'd0);
`endif
  endtask

  function automatic vec_t mkRow(input logic rst, input logic [N-1:0] vld, input int lane,
                                 input logic [W-1:0] d, input logic ev, input logic [W-1:0] ed,
                                 input logic [1:0] eix);
    vec_t r;
    r.rst       = rst;
    r.vld       = vld;
    r.dat       = '0;
    r.dat[lane] = d;
    r.rdy       = 1'b1;
    r.ev        = ev;
    r.ed        = ed;
    r.eix       = eix;
    return r;
  endfunction

  initial begin
    logic [N-1:0]        v;
    logic [N-1:0][W-1:0] d;
    int                  left;

    // In-order lanes: words leave two cycles after their lane strobe.
    tbl[0]  = mkRow(1'b1, 4'b0001, 0, 6'h01, 1'b0, 6'h00, 2'd0);
    tbl[1]  = mkRow(1'b0, 4'b0010, 1, 6'h02, 1'b0, 6'h00, 2'd0);
    tbl[2]  = mkRow(1'b0, 4'b0100, 2, 6'h03, 1'b1, 6'h01, 2'd1);
    tbl[3]  = mkRow(1'b0, 4'b1000, 3, 6'h04, 1'b1, 6'h02, 2'd2);
    tbl[4]  = mkRow(1'b0, 4'b0000, 0, 6'h00, 1'b1, 6'h03, 2'd3);
    tbl[5]  = mkRow(1'b0, 4'b0000, 0, 6'h00, 1'b1, 6'h04, 2'd0);
    tbl[6]  = mkRow(1'b0, 4'b0000, 0, 6'h00, 1'b0, 6'h00, 2'd0);
    // Out-of-order lanes: nothing leaves until lane 0 has a word.
    tbl[7]  = mkRow(1'b1, 4'b0100, 2, 6'h22, 1'b0, 6'h00, 2'd0);
    tbl[8]  = mkRow(1'b0, 4'b0010, 1, 6'h11, 1'b0, 6'h00, 2'd0);
    tbl[9]  = mkRow(1'b0, 4'b0001, 0, 6'h00, 1'b0, 6'h00, 2'd0);
    tbl[10] = mkRow(1'b0, 4'b0000, 0, 6'h00, 1'b0, 6'h00, 2'd0);
    tbl[11] = mkRow(1'b0, 4'b0000, 0, 6'h00, 1'b1, 6'h00, 2'd1);
    tbl[12] = mkRow(1'b0, 4'b0000, 0, 6'h00, 1'b1, 6'h11, 2'd2);
    tbl[13] = mkRow(1'b0, 4'b0000, 0, 6'h00, 1'b1, 6'h22, 2'd3);
    tbl[14] = mkRow(1'b0, 4'b0000, 0, 6'h00, 1'b0, 6'h00, 2'd3);

    for (int r = 0; r < 15; r++) begin
      if (tbl[r].rst) resetDut();
      checkOutput($sformatf("row%0d_valid", r), 32'(valid_out), 32'(tbl[r].ev));
      checkOutput($sformatf("row%0d_ix", r), 32'(ix_out), 32'(tbl[r].eix));
      if (tbl[r].ev) checkOutput($sformatf("row%0d_data", r), 32'(data_out), 32'(tbl[r].ed));
      applyStimulus(tbl[r].vld, tbl[r].dat, tbl[r].rdy, tbl[r].vld);
      tick();
    end

    // Lane 1 fills while lane 0 is empty; the third write is dropped.
    resetDut();
    applyStimulus(4'b0010, {6'h00, 6'h00, 6'h31, 6'h00}, 1'b1, 4'b0010);
    tick();
    checkOutput("ovf_ready_1st", 32'(lane_ready_out), 32'hF);
    applyStimulus(4'b0010, {6'h00, 6'h00, 6'h32, 6'h00}, 1'b1, 4'b0010);
    tick();
    checkOutput("ovf_ready_full", 32'(lane_ready_out), 32'hD);
    checkOutput("ovf_flag_before", 32'(overflow_out), 32'd0);
    applyStimulus(4'b0010, {6'h00, 6'h00, 6'h33, 6'h00}, 1'b1, 4'b0000);
    tick();
    checkOutput("ovf_flag_set", 32'(overflow_out), 32'd1);
    applyStimulus('0, '0, 1'b1, '0);
    repeat (3) tick();
    checkOutput("ovf_flag_sticky", 32'(overflow_out), 32'd1);
    checkOutput("ovf_stall_valid", 32'(valid_out), 32'd0);
    applyStimulus(4'b0001, {6'h00, 6'h00, 6'h00, 6'h30}, 1'b1, 4'b0001);
    tick();
    applyStimulus('0, '0, 1'b1, '0);
    repeat (5) tick();
    checkOutput("ovf_drain_ix", 32'(ix_out), 32'd2);
    checkOutput("ovf_drain_valid", 32'(valid_out), 32'd0);
    checkOutput("ovf_drain_flag", 32'(overflow_out), 32'd1);
    checkOutput("ovf_drain_ready", 32'(lane_ready_out), 32'hF);
`ifdef BUS_COLLECTOR_STATS_EN
    checkOutput("stats_words", word_count_out, 32'd2);
    checkOutput("stats_drops", 32'(drop_count_out), 32'd1);
`endif
    // Reset with a word still buffered in lane 1: nothing may come out afterwards.
    resetDut();
    repeat (3) tick();
    checkOutput("rst_mid_valid", 32'(valid_out), 32'd0);

    // A full lane that pops in the same cycle still drops the write.
    resetDut();
    applyStimulus(4'b0011, {6'h00, 6'h00, 6'h11, 6'h01}, 1'b0, 4'b0011);
    tick();
    applyStimulus(4'b0010, {6'h00, 6'h00, 6'h12, 6'h00}, 1'b0, 4'b0010);
    tick();
    checkOutput("credit_ready_full", 32'(lane_ready_out), 32'hD);
    checkOutput("credit_hold_data", 32'(data_out), 32'h01);
    applyStimulus(4'b0010, {6'h00, 6'h00, 6'h13, 6'h00}, 1'b1, 4'b0000);
    tick();
    checkOutput("credit_drop_flag", 32'(overflow_out), 32'd1);
    checkOutput("credit_ready_after", 32'(lane_ready_out), 32'hF);
    checkOutput("credit_next_data", 32'(data_out), 32'h11);
    applyStimulus('0, '0, 1'b1, '0);
    repeat (3) tick();
    checkOutput("credit_stall_valid", 32'(valid_out), 32'd0);
    checkOutput("credit_stall_ix", 32'(ix_out), 32'd2);

    // Backpressure with ready_in toggling; eight words wrap ix_out twice.
    resetDut();
    for (int k = 0; k < 40; k++) begin
      v = '0;
      d = '0;
      if ((k % 2 == 0) && (k < 16)) begin
        v[(k / 2) % N] = 1'b1;
        d[(k / 2) % N] = 6'(k / 2);
      end
      applyStimulus(v, d, (k % 2 == 1), v);
      tick();
    end
    applyStimulus('0, '0, 1'b1, '0);
    repeat (4) tick();
    left = 0;
    for (int i = 0; i < N; i++) left += lane_q[i].size();
    checkOutput("bp_words_left", 32'(left), 32'd0);
    checkOutput("bp_end_ix", 32'(ix_out), 32'd0);
    checkOutput("bp_end_valid", 32'(valid_out), 32'd0);
    checkOutput("bp_no_overflow", 32'(overflow_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
